sha3_padder_576: RTL and testbench

- Upstream neighbour of the Keccak f-permutation stage in the low-throughput SHA-3 core.
- Collects 32-bit message words into 576-bit (72-byte, 18-word) rate blocks and applies multi-rate padding to the final block.
- Presents each block to the permutation stage with a ready/ack handshake.
- Provides back-pressure to the message source through buffer_full.

---
 rtl/sha3_padder_576.sv | 150 +++++++++++++++
 tb/tb_sha3_padder_576.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_padder_576.sv
// Packs 32-bit message words into 576-bit rate blocks with multi-rate padding for the Keccak stage.
// Build option: define SHA3_DOMAIN_PAD_EN to use the SHA-3 first pad byte 0x06 instead of 0x01.
module sha3_padder_576 (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready,
  input  logic         f_ack
);

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

`ifdef SHA3_DOMAIN_PAD_EN
  localparam logic [7:0] PAD_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_BYTE = 8'h01;
`endif
  localparam logic [4:0]  LAST_SLOT  = 5'd17;
  localparam logic [31:0] FINAL_MARK = 32'h0000_0080;

  state_e         state_q, state_d;
  logic [575:0]   out_q, out_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           out_ready_q, out_ready_d;
  logic           buffer_full_q, buffer_full_d;
  logic           pad_done_q, pad_done_d;
  logic           shift_s;
  logic           padding_s;
  logic [31:0]    word_s;

  // Keep the valid leading bytes, place the pad byte, zero everything after it.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = {PAD_BYTE, 24'h00_0000};
      2'd1:    r = {w[31:24], PAD_BYTE, 16'h0000};
      2'd2:    r = {w[31:16], PAD_BYTE, 8'h00};
      2'd3:    r = {w[31:8], PAD_BYTE};
      default: r = {PAD_BYTE, 24'h00_0000};
    endcase
    return r;
  endfunction

  // Next-state, word selection and block assembly.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    out_ready_d = out_ready_q;
    pad_done_d  = pad_done_q;
    shift_s     = 1'b0;
    padding_s   = 1'b0;
    word_s      = 32'h0000_0000;

    case (state_q)
      ST_ABSORB: begin
        if (in_ready && !buffer_full_q) begin
          shift_s = 1'b1;
          if (is_last) begin
            word_s     = pad_word(in, byte_num);
            padding_s  = 1'b1;
            pad_done_d = 1'b1;
            state_d    = (cnt_q == LAST_SLOT) ? ST_FULL : ST_PAD;
          end else begin
            word_s  = in;
            state_d = (cnt_q == LAST_SLOT) ? ST_FULL : ST_ABSORB;
          end
          if (cnt_q == LAST_SLOT) begin
            out_ready_d = 1'b1;
          end else begin
            out_ready_d = 1'b0;
          end
        end else begin
          state_d = ST_ABSORB;
        end
      end
      ST_PAD: begin
        shift_s   = 1'b1;
        padding_s = pad_done_q;
        if (cnt_q == LAST_SLOT) begin
          out_ready_d = 1'b1;
          state_d     = ST_FULL;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_FULL: begin
        if (f_ack) begin
          out_ready_d = 1'b0;
          cnt_d       = 5'd0;
          pad_done_d  = 1'b0;
          state_d     = ST_ABSORB;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_ABSORB;
      end
    endcase

    // The 18th word of a padded block carries the closing 0x80 bit.
    if (shift_s) begin
      if (padding_s && (cnt_q == LAST_SLOT)) begin
        word_s = word_s | FINAL_MARK;
      end else begin
        word_s = word_s;
      end
      out_d = {out_q[543:0], word_s};
      cnt_d = cnt_q + 5'd1;
    end else begin
      out_d = out_d;
    end

    buffer_full_d = (state_d != ST_ABSORB);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ABSORB;
      out_q         <= 576'd0;
      cnt_q         <= 5'd0;
      out_ready_q   <= 1'b0;
      buffer_full_q <= 1'b0;
      pad_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      cnt_q         <= cnt_d;
      out_ready_q   <= out_ready_d;
      buffer_full_q <= buffer_full_d;
      pad_done_q    <= pad_done_d;
    end
  end

  assign out         = out_q;
  assign out_ready   = out_ready_q;
  assign buffer_full = buffer_full_q;

endmodule

// File: tb/tb_sha3_padder_576.sv
// Self-checking bench for sha3_padder_576: directed vector table, hand-written
// corner sequences and random messages checked against a byte-level padding model.
module tb_sha3_padder_576;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_w;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int checks   = 0;
  int failures = 0;

`ifdef SHA3_DOMAIN_PAD_EN
  localparam logic [7:0] P = 8'h06;
`else
  localparam logic [7:0] P = 8'h01;
`endif

  always #5 clk = ~clk;

  sha3_padder_576 dut (
    .clk(clk), .reset(reset), .in(in_w), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .buffer_full(buffer_full), .out(out), .out_ready(out_ready),
    .f_ack(f_ack)
  );

  task automatic chk_blk(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: message as a byte stream, padded as bytes.
  byte unsigned mq[$];
  int           mlen;

  function automatic logic [575:0] exp_block(input int b);
    logic [575:0] r;
    int           nb;
    int           j;
    logic [7:0]   v;
    r  = '0;
    nb = (mlen + 72) / 72;
    for (int i = 0; i < 72; i++) begin
      j = b * 72 + i;
      if (j < mlen) v = mq[j];
      else if (j == mlen) v = P;
      else v = 8'h00;
      if (j == nb * 72 - 1) v = v | 8'h80;
      r[575 - 8 * i -: 8] = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] msg_word(input int wi);
    logic [31:0] w;
    int          j;
    for (int k = 0; k < 4; k++) begin
      j = 4 * wi + k;
      w[31 - 8 * k -: 8] = (j < mlen) ? mq[j] : 8'($urandom);
    end
    return w;
  endfunction

  task automatic run_msg(input int len);
    int           nw, wi, bi, nb, delay, budget;
    bit           seen;
    logic [31:0]  cur;
    logic [575:0] e;
    mq.delete();
    mlen = len;
    for (int i = 0; i < len; i++) mq.push_back(8'($urandom_range(0, 255)));
    nw = len / 4 + 1;
    nb = (len + 72) / 72;
    wi = 0; bi = 0; delay = 0; seen = 0; budget = 0;
    e = '0;
    cur = msg_word(0);
    while (bi < nb && budget < 5000) begin
      f_ack = 1'b0;
      if (out_ready) begin
        if (!seen) begin
          e = exp_block(bi);
          chk_blk("rand_block", out, e);
          chk_b("rand_bf_in_full", buffer_full, 1'b1);
          seen  = 1;
          delay = $urandom_range(0, 4);
        end
        if (delay == 0) begin
          chk_blk("rand_hold", out, e);
          f_ack = 1'b1;
          bi++;
          seen = 0;
        end else begin
          delay--;
        end
      end
      if (wi < nw && $urandom_range(0, 3) != 0) begin
        in_ready = 1'b1;
        in_w     = cur;
        is_last  = (wi == nw - 1);
        byte_num = (wi == nw - 1) ? 2'(len % 4) : 2'($urandom);
      end else begin
        in_ready = 1'b0;
        in_w     = $urandom;
        is_last  = 1'($urandom);
        byte_num = 2'($urandom);
      end
      if (in_ready && !buffer_full) begin
        wi++;
        if (wi < nw) cur = msg_word(wi);
      end
      step();
      budget++;
    end
    f_ack    = 1'b0;
    in_ready = 1'b0;
    chk_w("rand_blocks_done", 32'(bi), 32'(nb));
  endtask

  typedef struct {
    logic [31:0] w;
    logic [1:0]  bn;
    int          pre;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t         tbl[7];
  logic [575:0] e1;
  int           n;

  initial begin
    tbl[0] = '{32'hDEADBEEF, 2'd0, 0,  17, {P, 24'h000000},      32'h0000_0080};
    tbl[1] = '{32'h61626300, 2'd3, 0,  17, {24'h616263, P},      32'h0000_0080};
    tbl[2] = '{32'h11223344, 2'd3, 17, 0,  32'hA5A5A5A5,         {24'h112233, P | 8'h80}};
    tbl[3] = '{32'hCAFEF00D, 2'd1, 5,  12, 32'hA5A5A5A5,         32'h0000_0080};
    tbl[4] = '{32'h12345678, 2'd2, 16, 1,  32'hA5A5A5A5,         32'h0000_0080};
    tbl[5] = '{32'hFFFFFFFF, 2'd0, 17, 0,  32'hA5A5A5A5,         {P, 16'h0000, 8'h80}};
    tbl[6] = '{32'h89ABCDEF, 2'd2, 0,  17, {16'h89AB, P, 8'h00}, 32'h0000_0080};

    reset = 1'b1; in_w = 32'h0; in_ready = 1'b0; is_last = 1'b0; byte_num = 2'd0; f_ack = 1'b0;
    @(negedge clk);
    step();
    chk_blk("reset_out", out, 576'd0);
    chk_b("reset_out_ready", out_ready, 1'b0);
    chk_b("reset_buffer_full", buffer_full, 1'b0);
    reset = 1'b0;
    step();

    // Directed table: prefill, final word, latency and padded boundary bytes.
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < tbl[v].pre; k++) begin
        in_ready = 1'b1; is_last = 1'b0; in_w = 32'hA5A5A5A5;
        step();
      end
      in_ready = 1'b1; is_last = 1'b1; in_w = tbl[v].w; byte_num = tbl[v].bn;
      step();
      in_ready = 1'b0; is_last = 1'b0;
      n = 0;
      while (!out_ready && n < 40) begin
        step();
        n++;
      end
      chk_w("tbl_latency", 32'(n), 32'(tbl[v].lat));
      chk_w("tbl_first_word", out[575:544], tbl[v].hi);
      chk_w("tbl_last_word", out[31:0], tbl[v].lo);
      chk_b("tbl_buffer_full", buffer_full, 1'b1);
      f_ack = 1'b1;
      step();
      f_ack = 1'b0;
      chk_b("tbl_ack_out_ready", out_ready, 1'b0);
      chk_b("tbl_ack_buffer_full", buffer_full, 1'b0);
    end

    // 72-byte message: full data block, stall, then an all-padding block.
    e1 = '0;
    for (int k = 0; k < 18; k++) begin
      in_ready = 1'b1; is_last = 1'b0; in_w = 32'h10000000 + 32'(k);
      e1 = {e1[543:0], in_w};
      step();
    end
    in_w = 32'hDDDDDDDD; is_last = 1'b1; byte_num = 2'd0;
    chk_b("m72_ready", out_ready, 1'b1);
    chk_blk("m72_block1", out, e1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_b("m72_stall_bf", buffer_full, 1'b1);
      chk_blk("m72_stall_out", out, e1);
    end
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk_b("m72_ack_ready", out_ready, 1'b0);
    chk_b("m72_ack_bf", buffer_full, 1'b0);
    chk_blk("m72_no_same_cycle_accept", out, e1);
    step();
    in_ready = 1'b0; is_last = 1'b0;
    n = 0;
    while (!out_ready && n < 40) begin
      step();
      n++;
    end
    chk_w("m72_pad_latency", 32'(n), 32'd17);
    chk_blk("m72_block2", out, {P, 560'd0, 8'h80});
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;

    // Reset mid-block discards the partial block.
    for (int k = 0; k < 5; k++) begin
      in_ready = 1'b1; is_last = 1'b0; in_w = $urandom;
      step();
    end
    in_ready = 1'b0;
    reset = 1'b1;
    step();
    chk_blk("midreset_out", out, 576'd0);
    chk_b("midreset_out_ready", out_ready, 1'b0);
    chk_b("midreset_bf", buffer_full, 1'b0);
    reset = 1'b0;
    run_msg(11);

    // Random messages including block-boundary lengths.
    run_msg(0);
    run_msg(3);
    run_msg(4);
    run_msg(71);
    run_msg(72);
    run_msg(143);
    run_msg(144);
    for (int r = 0; r < 20; r++) run_msg($urandom_range(0, 200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
